// File: rtl/mom_stream_filter.sv
// mom_stream_filter: two-stage 3x3 median-of-medians (or centre bypass) filter over a 5-row pixel stream.
module mom_stream_filter #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [5*(3*LANES+2)*PIX_W-1:0] pixel_in,
  input  logic                         in_mode,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*9*PIX_W-1:0]     block_out,
  output logic                         out_last,
  output logic [CNT_W-1:0]             frame_cnt
);
  localparam int W = 3*LANES+2;
  localparam int X = 3*LANES;
  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, b, c);
    return (a > b) ? ((b > c) ? b : ((a > c) ? c : a))
                   : ((a > c) ? a : ((b > c) ? c : b));
  endfunction
  logic [PIX_W-1:0] w_p [5][W];
  logic [PIX_W-1:0] w_h [5][X];
  logic [PIX_W-1:0] r_h [5][X];
  logic [LANES*9*PIX_W-1:0] w_blk;
  logic w_en, r_v, r_mode, r_last;
  assign w_en = !(out_valid && !out_ready);
  assign in_ready = rst_n && w_en;
  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < W; c++) begin : g_pix
      assign w_p[r][c] = pixel_in[5*W*PIX_W-1-(r*W+c)*PIX_W -: PIX_W];
    end
    // In bypass mode stage 1 carries the centre pixel instead of the row median
    for (genvar x = 0; x < X; x++) begin : g_h
      assign w_h[r][x] = in_mode ? w_p[r][x+1] : med3(w_p[r][x], w_p[r][x+1], w_p[r][x+2]);
    end
  end
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    for (genvar r = 0; r < 3; r++) begin : g_br
      for (genvar c = 0; c < 3; c++) begin : g_bc
        assign w_blk[LANES*9*PIX_W-1-(9*j+3*r+c)*PIX_W -: PIX_W] = r_mode ? r_h[r+1][3*j+c]
          : med3(r_h[r][3*j+c], r_h[r+1][3*j+c], r_h[r+2][3*j+c]);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      block_out <= '0;
      frame_cnt <= '0;
    end else begin
      if (w_en) begin
        r_v       <= in_valid;
        r_h       <= w_h;
        r_mode    <= in_mode;
        r_last    <= in_valid && in_last;
        out_valid <= r_v;
        out_last  <= r_v && r_last;
        block_out <= r_v ? w_blk : block_out;
      end
      if (out_valid && out_ready && out_last) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/mom_stream_filter.md
MOM_STREAM_FILTER -- requirements
Module: mom_stream_filter

Interface
REQ-001: The block SHALL have parameter PIX_W, default 8, giving the unsigned pixel width in bits.
REQ-002: The block SHALL have parameter LANES, default 4, giving the number of 3x3 output blocks per beat; input width W = 3*LANES+2 columns.
REQ-003: The block SHALL have parameter CNT_W, default 16, giving the frame counter width.
REQ-004: One clock and a synchronous active-low reset SHALL be used, with ports clk and rst_n.
REQ-005: The ports SHALL be as follows:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat.
- pixel_in  in  5*W*PIX_W  5 rows x W cols.
- in_mode  in  1  0 = median-of-medians, 1 = centre bypass.
- in_last  in  1  last beat of frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- block_out  out  LANES*9*PIX_W  LANES 3x3 result blocks.
- out_last  out  1  in_last delayed with its beat.
- frame_cnt  out  CNT_W  count of completed frames.

Function
REQ-006: Input pixel P(r,c), with r in 0..4 and c in 0..W-1, SHALL sit at pixel_in[5*W*PIX_W-1-(r*W+c)*PIX_W -: PIX_W]. Row 0 is the most significant; column 0 is the leftmost and most significant within its row.
REQ-007: Output O(j,r,c), with j in 0..LANES-1 and r,c in 0..2, SHALL sit at block_out[LANES*9*PIX_W-1-(9*j+3*r+c)*PIX_W -: PIX_W]. Block 0 is the most significant and leftmost.
REQ-008: Define med3(a,b,c) as the unsigned median of three values, and H(r,x) = med3(P(r,x),P(r,x+1),P(r,x+2)).
- For mode 0: O(j,r,c) SHALL equal med3(H(r,x),H(r+1,x),H(r+2,x)), where x = 3j+c.
- For mode 1: O(j,r,c) SHALL equal P(r+1,3j+c+1).
REQ-009: All arithmetic SHALL be unsigned comparison only. There SHALL be no rounding and no width growth; outputs are PIX_W bits.
REQ-010: The pipeline SHALL have two register stages.
- Stage 1 registers the 5 x 3*LANES row medians H, together with mode, last and a valid bit.
- Stage 2 registers the column median or bypass into block_out, out_last and out_valid.
REQ-011: The global enable SHALL be en = !(out_valid && !out_ready), and in_ready SHALL equal rst_n && en. Both stages SHALL advance only when en=1.
REQ-012: A beat SHALL be accepted when in_valid && in_ready at a rising edge. Its result SHALL be presented with out_valid=1 after the second following enabled edge: latency 2 cycles when there is no stall.
REQ-013: in_mode and in_last SHALL be sampled with the beat they accompany. A mode change between consecutive beats SHALL affect only the later beat.
REQ-014: Bubbles SHALL propagate. A stage register loaded while its input valid is 0 SHALL carry valid=0. Bubbles are not collapsed.
REQ-015: While out_valid && !out_ready, block_out, out_last, out_valid and stage-1 contents SHALL be held unchanged.
REQ-016: in_valid high while in_ready=0 SHALL have no effect. The upstream holds the beat.
REQ-017: frame_cnt SHALL increment by 1 at each output handshake (out_valid && out_ready) where out_last=1, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-018: Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-019: When out_valid=0, block_out SHALL hold its last value. It is don't-care to the sink.

Reset
REQ-020: When rst_n=0 at a rising edge, the following SHALL be cleared to 0: out_valid, the stage-1 valid bit, out_last, block_out and frame_cnt.
REQ-021: While rst_n=0, in_ready SHALL be 0. An in-flight beat at reset mid-operation SHALL be discarded and never presented.
REQ-022: In the first cycle after rst_n returns to 1, in_ready SHALL be 1. The first accepted beat SHALL produce out_valid exactly 2 cycles later.

Verification
REQ-023: Impulse test: PIX_W=8, LANES=4, mode 0, all pixels 0 except P(2,5)=255 -> all 36 outputs are 0, out_valid=1 at cycle 2.
REQ-024: Row gradient test: mode 0, P(r,c)=10*c -> O(j,r,c)=10*(3j+c+1). The same input with mode 1 gives identical values.
REQ-025: Backpressure test: stream 6 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, block_out stable, all 6 results in order, none lost or duplicated.
REQ-026: Mode test: alternating mode 0/1 beats with P(r,c)=(r*31+c*7) mod 256 -> each output matches the reference model for its own mode.
REQ-027: Frame counter test: CNT_W=2, 5 frames of 3 beats each with in_last on the third beat -> frame_cnt reads 1,2,3,0,1 after each frame's final output handshake.
REQ-028: Reset mid-operation test: assert rst_n=0 for 1 cycle with 2 beats in flight -> no out_valid for those beats, frame_cnt=0, and a new beat after reset appears 2 cycles later.
